// File: rtl/laundry_pkg.sv
// laundry_pkg
// Shared definitions for the laundromat washer scheduler:
//   - default requester / machine counts
//   - default run lengths (in clock cycles) for the three wash modes
//   - two-bit mode encoding and a small validity helper
//   - countdown timer width used by every machine_timer instance
package laundry_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int NMACH_DEF  = 4;

  localparam int DUR_M1_DEF = 24;  // soak + wash + rinse + spin
  localparam int DUR_M2_DEF = 16;  // wash + rinse + spin
  localparam int DUR_M3_DEF = 8;   // rinse + spin

  localparam int TIMER_W    = 16;

  localparam logic [1:0] MODE_INVALID = 2'b00;
  localparam logic [1:0] MODE_1       = 2'b01;
  localparam logic [1:0] MODE_2       = 2'b10;
  localparam logic [1:0] MODE_3       = 2'b11;

  function automatic logic modeValid(input logic [1:0] mode);
    return mode != MODE_INVALID;
  endfunction

endpackage

// File: rtl/machine_timer.sv
// machine_timer
// Countdown timer for a single washing machine.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (drops any running cycle silently)
//   load_i     start a run; load_val_i is captured on this edge
//   load_val_i run length in cycles
//   pause_i    hold the count while set (lid open)
//   busy_o     high while the count is non-zero
//   done_o     one-cycle pulse in the cycle the count reaches zero
module machine_timer
  import laundry_pkg::*;
#(
  parameter int TW = TIMER_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          pause_i,
  output logic          busy_o,
  output logic          done_o
);

  logic [TW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // Next count: a load wins, otherwise tick down unless paused. The done
  // pulse is registered alongside the final decrement so that it lines up
  // with the cycle in which busy drops.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if ((count_q != '0) && !pause_i) begin
      count_d = count_q - TW'(1);
      done_d  = (count_q == TW'(1));
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (count_q != '0);
  assign done_o = done_q;

endmodule

// File: rtl/washer_scheduler.sv
// washer_scheduler
// Round-robin assignment of coin-station requests to free washing machines.
// Optional feature macro: LAUNDRY_LID_PAUSE_EN -- when defined, an open lid
// pauses a running machine and makes a free machine ineligible for grant;
// when undefined, lid_open is ignored.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             level request per requester
//   req_mode        2-bit mode per requester, bits [2i+1:2i]
//   lid_open        lid status per machine
//   grant           one-hot grant pulse (registered)
//   grant_mach      index of the granted machine, 0 when no grant
//   machine_start   one-hot start pulse per machine
//   machine_mode    mode for the started machine, 0 when no grant
//   machine_busy    machine currently running
//   machine_done    one-cycle pulse when a run completes
//   reject          pulse for each requester holding an invalid mode
//   all_busy        every machine busy
module washer_scheduler
  import laundry_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int NMACH  = NMACH_DEF,
  parameter int DUR_M1 = DUR_M1_DEF,
  parameter int DUR_M2 = DUR_M2_DEF,
  parameter int DUR_M3 = DUR_M3_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [NMACH-1:0]  lid_open,
  output logic [NREQ-1:0]   grant,
  output logic [1:0]        grant_mach,
  output logic [NMACH-1:0]  machine_start,
  output logic [1:0]        machine_mode,
  output logic [NMACH-1:0]  machine_busy,
  output logic [NMACH-1:0]  machine_done,
  output logic [NREQ-1:0]   reject,
  output logic              all_busy
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef LAUNDRY_LID_PAUSE_EN
  localparam bit LidPauseEn = 1'b1;
`else
  localparam bit LidPauseEn = 1'b0;
`endif

  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    reject_q, reject_d;
  logic [NMACH-1:0]   start_q, start_d;
  logic [1:0]         gmach_q, gmach_d;
  logic [1:0]         mode_q, mode_d;
  logic [RW-1:0]      rr_q, rr_d;

  logic [NREQ-1:0]    eligible;
  logic [NMACH-1:0]   machFree;
  logic [NMACH-1:0]   busy;
  logic [NMACH-1:0]   done;
  logic [TIMER_W-1:0] loadVal;
  logic               winFound, machFound;
  int                 win, mach, idx;

  // Arbitration. A machine whose done pulse is showing this cycle is held
  // back for one more sample so a freed machine is never handed out by the
  // same edge that retires it. Requesters granted last cycle sit out one
  // sample, which lets a held request rotate fairly through round-robin.
  always_comb begin
    grant_d   = '0;
    start_d   = '0;
    gmach_d   = '0;
    mode_d    = '0;
    rr_d      = rr_q;
    reject_d  = '0;
    eligible  = '0;
    machFree  = '0;
    loadVal   = '0;
    winFound  = 1'b0;
    machFound = 1'b0;
    win       = 0;
    mach      = 0;
    idx       = 0;

    for (int i = 0; i < NREQ; i++) begin
      reject_d[i] = req[i] && !modeValid(req_mode[2*i +: 2]);
      eligible[i] = req[i] && modeValid(req_mode[2*i +: 2]) && !grant_q[i];
    end

    for (int m = 0; m < NMACH; m++) begin
      machFree[m] = !busy[m] && !done[m] && !(LidPauseEn && lid_open[m]);
    end

    for (int m = 0; m < NMACH; m++) begin
      if (!machFound && machFree[m]) begin
        machFound = 1'b1;
        mach      = m;
      end
    end

    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!winFound && eligible[idx]) begin
        winFound = 1'b1;
        win      = idx;
      end
    end

    if (winFound && machFound) begin
      grant_d[win]  = 1'b1;
      start_d[mach] = 1'b1;
      gmach_d       = 2'(mach);
      mode_d        = req_mode[2*win +: 2];
      rr_d          = RW'((win + 1) % NREQ);
      case (mode_d)
        MODE_1:  loadVal = TIMER_W'(DUR_M1);
        MODE_2:  loadVal = TIMER_W'(DUR_M2);
        MODE_3:  loadVal = TIMER_W'(DUR_M3);
        default: loadVal = '0;
      endcase
    end
  end

  // Registered grant/start outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      reject_q <= '0;
      start_q  <= '0;
      gmach_q  <= '0;
      mode_q   <= '0;
      rr_q     <= '0;
    end else begin
      grant_q  <= grant_d;
      reject_q <= reject_d;
      start_q  <= start_d;
      gmach_q  <= gmach_d;
      mode_q   <= mode_d;
      rr_q     <= rr_d;
    end
  end

  // Timers load on the same edge that registers machine_start, so busy
  // rises together with the start pulse.
  for (genvar m = 0; m < NMACH; m++) begin : g_mach
    machine_timer #(.TW(TIMER_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (start_d[m]),
      .load_val_i(loadVal),
      .pause_i   (lid_open[m] & LidPauseEn),
      .busy_o    (busy[m]),
      .done_o    (done[m])
    );
  end

  assign grant         = grant_q;
  assign grant_mach    = gmach_q;
  assign machine_start = start_q;
  assign machine_mode  = mode_q;
  assign machine_busy  = busy;
  assign machine_done  = done;
  assign reject        = reject_q;
  assign all_busy      = &busy;

endmodule

// File: tb/tb_washer_scheduler.sv
// tb_washer_scheduler
// Directed bench for washer_scheduler with default parameters
// (4 requesters, 4 machines, run lengths 24/16/8). Honours
// LAUNDRY_LID_PAUSE_EN for the lid-dependent expectations.
module tb_washer_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_mode;
  logic [3:0] lid_open;
  logic [3:0] grant;
  logic [1:0] grant_mach;
  logic [3:0] machine_start;
  logic [1:0] machine_mode;
  logic [3:0] machine_busy;
  logic [3:0] machine_done;
  logic [3:0] reject;
  logic       all_busy;

  int checks;
  int failures;
  int cnt;
  int sawFlag;

  washer_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_mode     (req_mode),
    .lid_open     (lid_open),
    .grant        (grant),
    .grant_mach   (grant_mach),
    .machine_start(machine_start),
    .machine_mode (machine_mode),
    .machine_busy (machine_busy),
    .machine_done (machine_done),
    .reject       (reject),
    .all_busy     (all_busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] m, input logic [3:0] l);
    req      = r;
    req_mode = m;
    lid_open = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: each step ticks into a cycle, checks what that cycle
  // shows, then drives the inputs for the next sampling edge.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(4'b0000, 8'h00, 4'b0000);
    tick();
    tick();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_busy", 32'(machine_busy), 32'h0);
    checkOutput("rst_allbusy", 32'(all_busy), 32'h0);
    checkOutput("rst_done", 32'(machine_done), 32'h0);
    checkOutput("rst_gmach", 32'(grant_mach), 32'h0);
    checkOutput("rst_mode", 32'(machine_mode), 32'h0);
    rst = 1'b0;

    // Single mode-1 request; machine 0 runs 24 cycles.
    $display("[TB] single request mode 1");
    applyStimulus(4'b0001, 8'b01010101, 4'b0000);
    tick();
    checkOutput("t1_grant", 32'(grant), 32'h1);
    checkOutput("t1_gmach", 32'(grant_mach), 32'h0);
    checkOutput("t1_start", 32'(machine_start), 32'h1);
    checkOutput("t1_mode", 32'(machine_mode), 32'h1);
    checkOutput("t1_busy", 32'(machine_busy), 32'h1);
    applyStimulus(4'b0000, 8'b01010101, 4'b0000);
    tick();
    checkOutput("t1_grant_pulse", 32'(grant), 32'h0);
    checkOutput("t1_start_pulse", 32'(machine_start), 32'h0);
    cnt = 1;
    while (machine_done[0] !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checkOutput("t1_done_latency", 32'(cnt), 32'd24);
    checkOutput("t1_busy_at_done", 32'(machine_busy), 32'h0);
    tick();
    checkOutput("t1_done_pulse", 32'(machine_done), 32'h0);

    // Fresh pointer, then all four requesters hold mode 2.
    $display("[TB] four requesters round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1111, 8'b10101010, 4'b0000);
    tick();
    checkOutput("t2_g0", 32'(grant), 32'h1);
    checkOutput("t2_m0", 32'(grant_mach), 32'h0);
    checkOutput("t2_mode", 32'(machine_mode), 32'h2);
    tick();
    checkOutput("t2_g1", 32'(grant), 32'h2);
    checkOutput("t2_m1", 32'(grant_mach), 32'h1);
    tick();
    checkOutput("t2_g2", 32'(grant), 32'h4);
    checkOutput("t2_m2", 32'(grant_mach), 32'h2);
    tick();
    checkOutput("t2_g3", 32'(grant), 32'h8);
    checkOutput("t2_m3", 32'(grant_mach), 32'h3);
    checkOutput("t2_allbusy", 32'(all_busy), 32'h1);
    tick();
    checkOutput("t2_nogrant_full", 32'(grant), 32'h0);
    checkOutput("t2_gmach_zero", 32'(grant_mach), 32'h0);
    checkOutput("t2_mode_zero", 32'(machine_mode), 32'h0);

    // All busy, only requester 2 waiting; machine 0 frees first.
    $display("[TB] wait for a free machine");
    applyStimulus(4'b0100, 8'b10101010, 4'b0000);
    sawFlag = 0;
    cnt = 0;
    while (machine_done === 4'b0000 && cnt < 40) begin
      if (grant !== 4'b0000) sawFlag = 1;
      tick();
      cnt++;
    end
    checkOutput("t3_done_which", 32'(machine_done), 32'h1);
    checkOutput("t3_done_time", 32'(cnt), 32'd12);
    checkOutput("t3_no_early_grant", 32'(sawFlag), 32'h0);
    checkOutput("t3_grant_d0", 32'(grant), 32'h0);
    tick();
    checkOutput("t3_grant_d1", 32'(grant), 32'h0);
    tick();
    checkOutput("t3_grant_d2", 32'(grant), 32'h4);
    checkOutput("t3_gmach_d2", 32'(grant_mach), 32'h0);
    checkOutput("t3_start_d2", 32'(machine_start), 32'h1);

    // Requester 1 with invalid mode for three sampled cycles.
    $display("[TB] invalid mode reject");
    applyStimulus(4'b0010, 8'b10100010, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t4_reject", 32'(reject), 32'h2);
      checkOutput("t4_nogrant", 32'(grant), 32'h0);
    end
    applyStimulus(4'b0000, 8'b10100010, 4'b0000);
    tick();
    checkOutput("t4_reject_off", 32'(reject), 32'h0);
    // Pointer should still sit at 3 after the last real grant to requester 2.
    applyStimulus(4'b1111, 8'hFF, 4'b0000);
    tick();
    checkOutput("t4_rr_grant", 32'(grant), 32'h8);
    checkOutput("t4_rr_gmach", 32'(grant_mach), 32'h1);
    checkOutput("t4_rr_mode", 32'(machine_mode), 32'h3);
    tick();
    checkOutput("t4_rr_next", 32'(grant), 32'h1);
    checkOutput("t4_rr_next_m", 32'(grant_mach), 32'h2);
    applyStimulus(4'b0000, 8'hFF, 4'b0000);

    // Mode 3 on machine 0 with the lid open for 5 sampled cycles mid-run.
    $display("[TB] lid open mid-run");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_rst_busy", 32'(machine_busy), 32'h0);
    applyStimulus(4'b0001, 8'hFF, 4'b0000);
    tick();
    checkOutput("t5_start", 32'(machine_start), 32'h1);
    checkOutput("t5_mode", 32'(machine_mode), 32'h3);
    applyStimulus(4'b0000, 8'hFF, 4'b0000);
    cnt = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (machine_done[0] === 1'b1) break;
      if (cnt == 3) lid_open = 4'b0001;
      if (cnt == 8) lid_open = 4'b0000;
    end
    lid_open = 4'b0000;
`ifdef LAUNDRY_LID_PAUSE_EN
    checkOutput("t5_done_time", 32'(cnt), 32'd13);
`else
    checkOutput("t5_done_time", 32'(cnt), 32'd8);
`endif
    tick();
    tick();
    applyStimulus(4'b0010, 8'hFF, 4'b0001);
    tick();
    checkOutput("t5_lid_grant", 32'(grant), 32'h2);
`ifdef LAUNDRY_LID_PAUSE_EN
    checkOutput("t5_lid_gmach", 32'(grant_mach), 32'h1);
`else
    checkOutput("t5_lid_gmach", 32'(grant_mach), 32'h0);
`endif
    applyStimulus(4'b0000, 8'hFF, 4'b0000);

    // Reset while machines 0-2 are running.
    $display("[TB] reset mid-run");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b0111, 8'b01010101, 4'b0000);
    tick();
    checkOutput("t6_g0", 32'(grant), 32'h1);
    tick();
    checkOutput("t6_g1", 32'(grant), 32'h2);
    tick();
    checkOutput("t6_g2", 32'(grant), 32'h4);
    checkOutput("t6_g2_m", 32'(grant_mach), 32'h2);
    applyStimulus(4'b0000, 8'b01010101, 4'b0000);
    tick();
    tick();
    tick();
    checkOutput("t6_busy_pre", 32'(machine_busy), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_busy_post", 32'(machine_busy), 32'h0);
    checkOutput("t6_allbusy_post", 32'(all_busy), 32'h0);
    sawFlag = 0;
    for (int k = 0; k < 30; k++) begin
      if (machine_done !== 4'b0000) sawFlag = 1;
      tick();
    end
    checkOutput("t6_no_done", 32'(sawFlag), 32'h0);
    applyStimulus(4'b1111, 8'b01010101, 4'b0000);
    tick();
    checkOutput("t6_after_grant", 32'(grant), 32'h1);
    checkOutput("t6_after_gmach", 32'(grant_mach), 32'h0);
    checkOutput("t6_after_start", 32'(machine_start), 32'h1);
    applyStimulus(4'b0000, 8'b01010101, 4'b0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
